alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//   8-bit registered ALU for the datapath's execute stage. Selects one of 16
//   operations on inA/inB by alu_cmd. Result and carry are captured on the
//   rising clock edge. shiftcarry_in/shiftcarry_out chain multi-byte shifts
//   and add/sub.
// PARAMETERS
//   none (data width fixed at 8, command width fixed at 4)
// PORTS
//   clk             in   1  system clock, rising-edge active
//   reset           in   1  asynchronous, active-high reset
//   alu_cmd         in   4  operation select (table below)
//   inA             in   8  operand A
//   inB             in   8  operand B
//   shiftcarry_in   in   1  carry/shift-in bit from previous byte
//   rslt            out  8  registered result
//   shiftcarry_out  out  1  registered carry/shift-out bit
//   zero            out  1  combinational, 1 when rslt == 8'h00
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset: rslt=8'h00, shiftcarry_out=0, so zero=1. Held while reset=1.
//   Latency: 1 cycle. Inputs sampled at a rising clk edge appear on rslt/
//     shiftcarry_out after that edge. No handshake. Every cycle computes.
//   Reset deasserting mid-operation: the first edge after release computes
//     normally.
//   All arithmetic is unsigned modulo 256. Carry uses a 9-bit internal sum.
//   co below = next shiftcarry_out. Ops with "co=0" clear it.
//   0000 AND   A & B                       co=0
//   0001 XOR   A ^ B                       co=0
//   0010 OR    A | B                       co=0
//   0011 LSL   {A[6:0], shiftcarry_in}     co=A[7]
//   0100 LSR   {shiftcarry_in, A[7:1]}     co=A[0]
//   0101 ADD   A + B                       co=carry out of bit 7
//   0110 SUB   A - B                       co=1 iff A < B (borrow)
//   0111 PASSA A                           co=0
//   1000 ADC   A + B + shiftcarry_in       co=carry out of bit 7
//   1001 SBB   A - B - shiftcarry_in       co=1 iff A < B+shiftcarry_in
//   1010 ASR   {A[7], A[7:1]}              co=A[0]
//   1011 NOTA  ~A                          co=0
//   1100 PASSB B                           co=0
//   1101 EQ    8'h01 if A==B else 8'h00    co=0
//   1110 LTU   8'h01 if A<B (unsigned)     co=0
//   1111 NOP   rslt and shiftcarry_out hold their previous values
//   Boundaries:
//   - ADD FF+01 gives 00 with co=1.
//   - SUB 00-01 gives FF with co=1.
//   - ADC FF+00+1 gives 00 with co=1.
//   - LSL/LSR with shiftcarry_in=1 insert a 1 at the vacated bit.
//   - shiftcarry_in is ignored by every op except LSL, LSR, ADC and SBB.
//   - No X propagation when inputs are stable. Fully synchronous apart from
//     reset.
// TESTING
//   Apply each vector, clock once, then check. Common inputs: A=AA, B=55,
//   shiftcarry_in=0.
//   1 Reset: assert reset mid-cycle -> rslt=00, shiftcarry_out=0, zero=1,
//     immediately with no clock edge.
//   2 Logic: AND -> 00 (zero=1). XOR -> FF. OR -> FF. PASSA -> AA.
//     NOTA -> 55. PASSB -> 55.
//   3 Shifts: LSL -> 54, co=1. LSR -> 55, co=0. ASR -> D5, co=0.
//     LSR with A=AA, shiftcarry_in=1 -> D5.
//   4 Arith: ADD -> FF, co=0. SUB -> 55, co=0. ADD FF+01 -> 00, co=1,
//     zero=1. SUB 00-01 -> FF, co=1.
//   5 Chain: 16-bit 01FF+0001 via ADD low then ADC high, feeding
//     shiftcarry_out back to shiftcarry_in -> 00, then 02.
//   6 Compare/NOP: EQ 3C,3C -> 01. LTU 10,20 -> 01. LTU 20,10 -> 00.
//     NOP -> prior rslt/co held.

Source files
------------

// File: rtl/alu_core_if.sv
// Bus bundle for the 8-bit execute-stage ALU: command/operands in, result out.
interface alu_core_if;
  logic [3:0] alu_cmd;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       shiftcarry_in;
  logic [7:0] rslt;
  logic       shiftcarry_out;
  logic       zero;

  // Issuer of commands (datapath control / testbench)
  modport master (
    output alu_cmd, inA, inB, shiftcarry_in,
    input  rslt, shiftcarry_out, zero
  );

  // The ALU itself
  modport slave (
    input  alu_cmd, inA, inB, shiftcarry_in,
    output rslt, shiftcarry_out, zero
  );
endinterface

// File: rtl/alu_core.sv
// 8-bit registered ALU. One-cycle latency, 16 ops, carry chaining for
// multi-byte add/sub/shift through shiftcarry_in/shiftcarry_out.
module alu_core (
  input  logic       clk,
  input  logic       reset,
  alu_core_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_AND   = 4'h0, OP_XOR  = 4'h1, OP_OR   = 4'h2, OP_LSL  = 4'h3,
    OP_LSR   = 4'h4, OP_ADD  = 4'h5, OP_SUB  = 4'h6, OP_PASSA = 4'h7,
    OP_ADC   = 4'h8, OP_SBB  = 4'h9, OP_ASR  = 4'hA, OP_NOTA = 4'hB,
    OP_PASSB = 4'hC, OP_EQ   = 4'hD, OP_LTU  = 4'hE, OP_NOP  = 4'hF
  } alu_op_e;

  logic [7:0] rslt_q, rslt_d;
  logic       co_q, co_d;
  logic [8:0] sum9;
  logic [8:0] dif9;
  logic [7:0] a, b;
  logic       ci;

  assign a  = bus.inA;
  assign b  = bus.inB;
  assign ci = bus.shiftcarry_in;

  // 9-bit add/subtract; bit 8 is carry for add, borrow for subtract.
  // The carry-in only enters the sum for ADC/SBB so it is ignored elsewhere.
  always_comb begin
    sum9 = {1'b0, a} + {1'b0, b};
    dif9 = {1'b0, a} - {1'b0, b};
    if (alu_op_e'(bus.alu_cmd) == OP_ADC) sum9 = sum9 + {8'd0, ci};
    if (alu_op_e'(bus.alu_cmd) == OP_SBB) dif9 = dif9 - {8'd0, ci};
  end

  // Next result/carry selection; NOP and the logic ops fall out of defaults.
  always_comb begin
    rslt_d = rslt_q;
    co_d   = 1'b0;
    case (alu_op_e'(bus.alu_cmd))
      OP_AND:   rslt_d = a & b;
      OP_XOR:   rslt_d = a ^ b;
      OP_OR:    rslt_d = a | b;
      OP_LSL:   begin rslt_d = {a[6:0], ci};   co_d = a[7]; end
      OP_LSR:   begin rslt_d = {ci, a[7:1]};   co_d = a[0]; end
      OP_ADD,
      OP_ADC:   begin rslt_d = sum9[7:0];      co_d = sum9[8]; end
      OP_SUB,
      OP_SBB:   begin rslt_d = dif9[7:0];      co_d = dif9[8]; end
      OP_PASSA: rslt_d = a;
      OP_ASR:   begin rslt_d = {a[7], a[7:1]}; co_d = a[0]; end
      OP_NOTA:  rslt_d = ~a;
      OP_PASSB: rslt_d = b;
      OP_EQ:    rslt_d = {7'd0, (a == b)};
      OP_LTU:   rslt_d = {7'd0, (a < b)};
      OP_NOP:   begin rslt_d = rslt_q;         co_d = co_q; end
      default:  begin rslt_d = rslt_q;         co_d = co_q; end
    endcase
  end

  // Result and carry registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rslt_q <= 8'h00;
      co_q   <= 1'b0;
    end else begin
      rslt_q <= rslt_d;
      co_q   <= co_d;
    end
  end

  assign bus.rslt           = rslt_q;
  assign bus.shiftcarry_out = co_q;
  assign bus.zero           = (rslt_q == 8'h00);

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: literal expectations per vector plus an
// arithmetic reference model compared against the DUT every cycle.
module tb_alu_core;

  logic clk;
  logic reset;
  alu_core_if bus ();

  alu_core dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit model_on = 0;

  // Reference model: integer arithmetic straight from the op table.
  int m_r  = 0;
  int m_co = 0;

  task automatic model_step(input int c, input int a, input int b, input int ci);
    int s;
    case (c)
      0:  begin m_r = a & b; m_co = 0; end
      1:  begin m_r = a ^ b; m_co = 0; end
      2:  begin m_r = a | b; m_co = 0; end
      3:  begin m_r = (a * 2 + ci) % 256; m_co = (a >= 128) ? 1 : 0; end
      4:  begin m_r = a / 2 + ci * 128; m_co = a % 2; end
      5:  begin s = a + b; m_r = s % 256; m_co = (s > 255) ? 1 : 0; end
      6:  begin m_r = (a - b + 256) % 256; m_co = (a < b) ? 1 : 0; end
      7:  begin m_r = a; m_co = 0; end
      8:  begin s = a + b + ci; m_r = s % 256; m_co = (s > 255) ? 1 : 0; end
      9:  begin m_r = (a - b - ci + 512) % 256; m_co = (a < b + ci) ? 1 : 0; end
      10: begin m_r = a / 2 + ((a >= 128) ? 128 : 0); m_co = a % 2; end
      11: begin m_r = 255 - a; m_co = 0; end
      12: begin m_r = b; m_co = 0; end
      13: begin m_r = (a == b) ? 1 : 0; m_co = 0; end
      14: begin m_r = (a < b) ? 1 : 0; m_co = 0; end
      default: ; // NOP keeps previous state
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r  = 0;
      m_co = 0;
    end else begin
      model_step(int'(bus.alu_cmd), int'(bus.inA), int'(bus.inB), int'(bus.shiftcarry_in));
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("model rslt", int'(bus.rslt), m_r);
      chk("model co",   int'(bus.shiftcarry_out), m_co);
      chk("model zero", int'(bus.zero), (m_r == 0) ? 1 : 0);
    end
  end

  task automatic apply(input string nm, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input bit chain,
                       input logic [7:0] er, input logic eco);
    @(negedge clk);
    bus.alu_cmd       = c;
    bus.inA           = a;
    bus.inB           = b;
    bus.shiftcarry_in = chain ? bus.shiftcarry_out : ci;
    @(posedge clk);
    #1;
    chk({nm, " rslt"}, int'(bus.rslt), int'(er));
    chk({nm, " co"},   int'(bus.shiftcarry_out), int'(eco));
    chk({nm, " zero"}, int'(bus.zero), (er == 8'h00) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.alu_cmd = 4'h0; bus.inA = 8'hAA; bus.inB = 8'h55; bus.shiftcarry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rslt", int'(bus.rslt), 0);
    chk("reset co",   int'(bus.shiftcarry_out), 0);
    chk("reset zero", int'(bus.zero), 1);
    @(negedge clk);
    reset = 1'b0;
    model_on = 1;

    // Logic
    apply("AND",   4'h0, 8'hAA, 8'h55, 1'b0, 0, 8'h00, 1'b0);
    apply("XOR",   4'h1, 8'hAA, 8'h55, 1'b0, 0, 8'hFF, 1'b0);
    apply("OR",    4'h2, 8'hAA, 8'h55, 1'b0, 0, 8'hFF, 1'b0);
    apply("PASSA", 4'h7, 8'hAA, 8'h55, 1'b0, 0, 8'hAA, 1'b0);
    apply("NOTA",  4'hB, 8'hAA, 8'h55, 1'b0, 0, 8'h55, 1'b0);
    apply("PASSB", 4'hC, 8'hAA, 8'h55, 1'b0, 0, 8'h55, 1'b0);
    // Shifts
    apply("LSL",   4'h3, 8'hAA, 8'h55, 1'b0, 0, 8'h54, 1'b1);
    apply("LSR",   4'h4, 8'hAA, 8'h55, 1'b0, 0, 8'h55, 1'b0);
    apply("ASR",   4'hA, 8'hAA, 8'h55, 1'b0, 0, 8'hD5, 1'b0);
    apply("LSR ci",4'h4, 8'hAA, 8'h55, 1'b1, 0, 8'hD5, 1'b0);
    apply("LSL ci",4'h3, 8'h2A, 8'h55, 1'b1, 0, 8'h55, 1'b0);
    apply("ASR 81",4'hA, 8'h81, 8'h00, 1'b1, 0, 8'hC0, 1'b1);
    // Arithmetic
    apply("ADD",   4'h5, 8'hAA, 8'h55, 1'b0, 0, 8'hFF, 1'b0);
    apply("ADD ci ignored", 4'h5, 8'hAA, 8'h55, 1'b1, 0, 8'hFF, 1'b0);
    apply("SUB",   4'h6, 8'hAA, 8'h55, 1'b0, 0, 8'h55, 1'b0);
    apply("ADD wrap", 4'h5, 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1);
    apply("SUB wrap", 4'h6, 8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1);
    apply("ADC wrap", 4'h8, 8'hFF, 8'h00, 1'b1, 0, 8'h00, 1'b1);
    apply("SBB",   4'h9, 8'h00, 8'h00, 1'b1, 0, 8'hFF, 1'b1);
    apply("SBB eq",4'h9, 8'h10, 8'h0F, 1'b1, 0, 8'h00, 1'b0);
    // 16-bit chain 01FF + 0001
    apply("chain lo", 4'h5, 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1);
    apply("chain hi", 4'h8, 8'h01, 8'h00, 1'b0, 1, 8'h02, 1'b0);
    // Compare
    apply("EQ",    4'hD, 8'h3C, 8'h3C, 1'b0, 0, 8'h01, 1'b0);
    apply("EQ ne", 4'hD, 8'h3C, 8'h3D, 1'b0, 0, 8'h00, 1'b0);
    apply("LTU lt",4'hE, 8'h10, 8'h20, 1'b0, 0, 8'h01, 1'b0);
    apply("LTU gt",4'hE, 8'h20, 8'h10, 1'b0, 0, 8'h00, 1'b0);
    // NOP holds both result and carry
    apply("pre NOP", 4'h6, 8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1);
    apply("NOP",     4'hF, 8'h12, 8'h34, 1'b1, 0, 8'hFF, 1'b1);
    apply("NOP 2",   4'hF, 8'h00, 8'h00, 1'b0, 0, 8'hFF, 1'b1);

    // Asynchronous reset mid-cycle, then held across an edge
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async rst rslt", int'(bus.rslt), 0);
    chk("async rst co",   int'(bus.shiftcarry_out), 0);
    chk("async rst zero", int'(bus.zero), 1);
    bus.alu_cmd = 4'h5; bus.inA = 8'hFF; bus.inB = 8'h01;
    @(posedge clk);
    #1;
    chk("held rst rslt", int'(bus.rslt), 0);
    chk("held rst co",   int'(bus.shiftcarry_out), 0);
    @(negedge clk);
    reset = 1'b0;
    apply("post rst", 4'h5, 8'h12, 8'h34, 1'b0, 0, 8'h46, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
